// File: rtl/multicycle_sequencer.sv
// rtl/multicycle_sequencer.sv - multicycle CPU control sequencer
//
// Purpose: drives the fetch/decode/execute/memory/writeback flow of a
// multicycle datapath. Memory strobes and status flags are decoded from the
// registered state only. The datapath enables (ir_write, reg_write, pc_write,
// pc_sel) may also depend on the current-cycle inputs.
//
// Optional feature: define MEM_TIMEOUT_EN to enable a memory wait timeout.
// FETCH or MEMORY then gives up after TIMEOUT_CYCLES consecutive
// mem_ready=0 cycles, moves to HALT and raises the sticky mem_error flag.
// In the default build FETCH and MEMORY wait forever and mem_error is 0.
//
// Ports:
//   clock        in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   start        in   begin/resume execution from IDLE or HALT
//   opcode       in   [5:0] latched instruction opcode (stable DECODE..FETCH)
//   mem_ready    in   memory handshake done (sampled in FETCH/MEMORY only)
//   branch_taken in   ALU branch condition (valid in EXECUTE)
//   imem_read    out  instruction fetch strobe
//   mem_read     out  data load strobe
//   mem_write    out  data store strobe
//   ir_write     out  instruction register load enable
//   reg_write    out  register file write enable
//   pc_write     out  PC update enable
//   pc_sel       out  [1:0] PC source: 00 PC+4, 01 branch, 10 jump, 11 JR
//   state        out  [2:0] current state code
//   halted       out  1 in HALT
//   busy         out  1 in any state except IDLE and HALT
//   mem_error    out  sticky memory timeout flag
//   instr_count  out  [CNT_W-1:0] count of PC updates, wraps

module multicycle_sequencer #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             imem_read,
  output logic             mem_read,
  output logic             mem_write,
  output logic             ir_write,
  output logic             reg_write,
  output logic             pc_write,
  output logic [1:0]       pc_sel,
  output logic [2:0]       state,
  output logic             halted,
  output logic             busy,
  output logic             mem_error,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    FETCH     = 3'd1,
    DECODE    = 3'd2,
    EXECUTE   = 3'd3,
    MEMORY    = 3'd4,
    WRITEBACK = 3'd5,
    HALT      = 3'd6
  } stateT;

  localparam logic [5:0] OP_J    = 6'b010001;
  localparam logic [5:0] OP_JAL  = 6'b010010;
  localparam logic [5:0] OP_JR   = 6'b010011;
  localparam logic [5:0] OP_LW   = 6'b011111;
  localparam logic [5:0] OP_SW   = 6'b100000;
  localparam logic [5:0] OP_HALT = 6'b111111;

  localparam logic [1:0] SEL_PC4    = 2'b00;
  localparam logic [1:0] SEL_BRANCH = 2'b01;
  localparam logic [1:0] SEL_JUMP   = 2'b10;
  localparam logic [1:0] SEL_REG    = 2'b11;

  // Elaboration-time guard against degenerate parameter values.
  if (TIMEOUT_CYCLES < 1 || CNT_W < 1) begin : gBadParams
    $error("multicycle_sequencer: TIMEOUT_CYCLES and CNT_W must be >= 1");
  end

  stateT            stateQ, stateD;
  logic             isLoadQ;
  logic [CNT_W-1:0] countQ;

  // Opcode classes used by EXECUTE.
  logic isBranch, isJump, isJr, isMemOp, isAlu;

  always_comb begin
    isBranch = (opcode >= 6'b010100) && (opcode <= 6'b011001);
    isJump   = (opcode == OP_J) || (opcode == OP_JAL);
    isJr     = (opcode == OP_JR);
    isMemOp  = (opcode == OP_LW) || (opcode == OP_SW);
    isAlu    = (opcode <= 6'b001111)
            || ((opcode >= 6'b011010) && (opcode <= 6'b011110))
            || (opcode == 6'b100001);
  end

`ifdef MEM_TIMEOUT_EN
  localparam int WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [WAIT_W-1:0] waitCnt;
  logic              memErrorQ;
  logic              timeoutHit;
  logic              waiting;

  // A handshake cycle that did not complete; only these advance the counter.
  assign waiting = ((stateQ == FETCH) || (stateQ == MEMORY)) && !mem_ready;
`endif

  // Next-state and datapath-enable logic.
  always_comb begin
    stateD    = stateQ;
    ir_write  = 1'b0;
    reg_write = 1'b0;
    pc_write  = 1'b0;
    pc_sel    = SEL_PC4;
`ifdef MEM_TIMEOUT_EN
    timeoutHit = 1'b0;
`endif
    case (stateQ)
      IDLE: begin
        if (start) stateD = FETCH;
      end
      FETCH: begin
        if (mem_ready) begin
          ir_write = 1'b1;
          stateD   = DECODE;
        end
`ifdef MEM_TIMEOUT_EN
        else if (waitCnt == WAIT_LAST) begin
          timeoutHit = 1'b1;
          stateD     = HALT;
        end
`endif
      end
      DECODE: begin
        stateD = (opcode == OP_HALT) ? HALT : EXECUTE;
      end
      EXECUTE: begin
        if (isBranch) begin
          pc_write = 1'b1;
          pc_sel   = branch_taken ? SEL_BRANCH : SEL_PC4;
          stateD   = FETCH;
        end else if (isJump) begin
          pc_write  = 1'b1;
          pc_sel    = SEL_JUMP;
          reg_write = (opcode == OP_JAL);  // link register write
          stateD    = FETCH;
        end else if (isJr) begin
          pc_write = 1'b1;
          pc_sel   = SEL_REG;
          stateD   = FETCH;
        end else if (isMemOp) begin
          stateD = MEMORY;
        end else if (isAlu) begin
          stateD = WRITEBACK;
        end else begin
          // Anything unassigned behaves as a NOP: just advance the PC.
          pc_write = 1'b1;
          stateD   = FETCH;
        end
      end
      MEMORY: begin
        if (mem_ready) begin
          if (isLoadQ) begin
            stateD = WRITEBACK;
          end else begin
            pc_write = 1'b1;
            stateD   = FETCH;
          end
        end
`ifdef MEM_TIMEOUT_EN
        else if (waitCnt == WAIT_LAST) begin
          timeoutHit = 1'b1;
          stateD     = HALT;
        end
`endif
      end
      WRITEBACK: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        stateD    = FETCH;
      end
      HALT: begin
        // Resume without touching the PC; the next fetch uses the held PC.
        if (start) stateD = FETCH;
      end
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stateQ <= IDLE;
    end else begin
      stateQ <= stateD;
    end
  end

  // Remember load vs store when entering MEMORY so the memory strobes stay
  // pure state decodes rather than following the opcode input.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      isLoadQ <= 1'b0;
    end else if (stateQ == EXECUTE && stateD == MEMORY) begin
      isLoadQ <= (opcode == OP_LW);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      countQ <= '0;
    end else if (pc_write) begin
      countQ <= countQ + CNT_W'(1);
    end
  end

`ifdef MEM_TIMEOUT_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      waitCnt <= '0;
    end else if (stateD != stateQ) begin
      waitCnt <= '0;
    end else if (waiting) begin
      waitCnt <= waitCnt + WAIT_W'(1);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      memErrorQ <= 1'b0;
    end else if (timeoutHit) begin
      memErrorQ <= 1'b1;
    end else if (stateQ == HALT && start) begin
      memErrorQ <= 1'b0;
    end
  end

  assign mem_error = memErrorQ;
`else
  assign mem_error = 1'b0;
`endif

  // Moore decodes of the registered state; only one strobe state is active.
  assign imem_read   = (stateQ == FETCH);
  assign mem_read    = (stateQ == MEMORY) && isLoadQ;
  assign mem_write   = (stateQ == MEMORY) && !isLoadQ;
  assign halted      = (stateQ == HALT);
  assign busy        = (stateQ != IDLE) && (stateQ != HALT);
  assign state       = stateQ;
  assign instr_count = countQ;

endmodule
